// File: rtl/sub64_pkg.sv
// Shared constants and state encoding for the sequential subtractor.
// Define SUB64_SEQ_FAST_EN to use 16-bit slices instead of 8-bit slices.
package sub64_pkg;
    localparam int DATA_W = 64;
`ifdef SUB64_SEQ_FAST_EN
    localparam int SLICE_W = 16;
`else
    localparam int SLICE_W = 8;
`endif
    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/sub64_seq_sub_slice.sv
// One slice of the adder: a + nb + cin, where nb is the already-inverted subtrahend.
module sub_slice
    import sub64_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] nb_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cmsb_o,
    output logic               cout_o
);
    logic [SLICE_W-1:0] low;

    // Split at the MSB so the carry into it is visible for overflow detection.
    assign low = {1'b0, a_i[SLICE_W-2:0]} + {1'b0, nb_i[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin_i};
    assign cmsb_o = low[SLICE_W-1];
    assign {cout_o, sum_o[SLICE_W-1]} = {1'b0, a_i[SLICE_W-1]} + {1'b0, nb_i[SLICE_W-1]} + {1'b0, cmsb_o};
    assign sum_o[SLICE_W-2:0] = low[SLICE_W-2:0];
endmodule

// File: rtl/sub64_seq.sv
// Multi-cycle signed subtractor a - b, one slice per clock, LSB slice first.
// Slice width comes from sub64_pkg (SUB64_SEQ_FAST_EN selects 16-bit slices).
module sub64_seq
    import sub64_pkg::*;
#(
    parameter int DATA_W = sub64_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] diff,
    output logic              overflow,
    output logic              zf,
    output logic              sf,
    output logic              borrow
);
    localparam int NSL = DATA_W / SLICE_W;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int AW  = DATA_W - SLICE_W;
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    state_e state_q, state_d;

    logic [DATA_W-1:0] a_q, nb_q;
    logic [AW-1:0]     acc_q;
    logic              c_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] diff_q;
    logic              ov_q, zf_q, sf_q, borrow_q;

    logic [SLICE_W-1:0] s_sum;
    logic               s_cmsb, s_cout;
    logic [DATA_W-1:0]  diff_d;
    logic               last;

    sub_slice u_slice (
        .a_i   (a_q[SLICE_W-1:0]),
        .nb_i  (nb_q[SLICE_W-1:0]),
        .cin_i (c_q),
        .sum_o (s_sum),
        .cmsb_o(s_cmsb),
        .cout_o(s_cout)
    );

    assign last   = (idx_q == LAST);
    assign diff_d = {s_sum, acc_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            nb_q     <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            ov_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                a_q   <= a;
                nb_q  <= ~b;
                c_q   <= 1'b1;
                idx_q <= '0;
            end
        end else if (state_q == RUN) begin
            a_q   <= a_q >> SLICE_W;
            nb_q  <= nb_q >> SLICE_W;
            c_q   <= s_cout;
            idx_q <= idx_q + 1'b1;
            acc_q <= diff_d[DATA_W-1:SLICE_W];
            // Results are published only on the final slice so they stay stable otherwise.
            if (last) begin
                diff_q   <= diff_d;
                ov_q     <= s_cmsb ^ s_cout;
                zf_q     <= (diff_d == '0);
                sf_q     <= s_sum[SLICE_W-1];
                borrow_q <= ~s_cout;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign overflow = ov_q;
    assign zf       = zf_q;
    assign sf       = sf_q;
    assign borrow   = borrow_q;
endmodule

// File: tb/tb_sub64_seq.sv
// Randomized self-checking bench for sub64_seq against an arithmetic reference model.
module tb_sub64_seq;
    localparam int NSL = sub64_pkg::NUM_SLICES;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] a, b;
    logic        busy, done, overflow, zf, sf, borrow;
    logic [63:0] diff;

    int n_cmp = 0;
    int n_err = 0;

    sub64_seq #(.DATA_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .overflow(overflow), .zf(zf), .sf(sf), .borrow(borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Issues one subtraction; optionally pulses a stray start during RUN.
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input bit inject);
        int          cyc;
        bit          seen;
        logic [63:0] ed;
        logic        eov, eborrow;
        ed      = av - bv;
        eborrow = (av < bv);
        eov     = (av[63] != bv[63]) && (ed[63] != av[63]);

        @(negedge clk); start = 1'b1; a = av; b = bv;
        @(negedge clk); start = 1'b0; a = rnd64(); b = rnd64();
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 64) begin
            if (done) seen = 1;
            else begin
                if (inject && cyc == 2) begin
                    start = 1'b1; a = 64'd1; b = 64'd1;
                end else start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        chk("latency", 64'(cyc), 64'(NSL + 1));
        chk("diff", diff, ed);
        chk("flags", {60'd0, overflow, zf, sf, borrow},
            {60'd0, eov, (ed == 64'd0), ed[63], eborrow});
        // start while done is high must be dropped
        start = 1'b1; a = rnd64(); b = rnd64();
        @(negedge clk); start = 1'b0;
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        chk("diff_held", diff, ed);
    endtask

    initial begin
        int          cyc;
        logic [63:0] ra, rb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 64'd7;
        @(negedge clk);
        chk("reset_state", {58'd0, busy, done, overflow, zf, sf, borrow}, 64'd0);
        chk("reset_diff", diff, 64'd0);
        start = 1'b0; rst = 1'b0;

        run_op(64'd5, 64'd3, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 0);
        run_op(64'd0, 64'd1, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(64'd9, 64'd4, 1);

        for (int i = 0; i < 20; i++) begin
            ra = rnd64();
            rb = (i % 5 == 0) ? ra : rnd64();
            if (i % 7 == 3) rb = {ra[63:8], rb[7:0]};
            run_op(ra, rb, 0);
        end

        // abort in the 4th RUN cycle
        @(negedge clk); start = 1'b1; a = 64'd20; b = 64'd1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_state", {62'd0, busy, done}, 64'd0);
        chk("abort_diff", diff, 64'd0);
        cyc = 0;
        repeat (NSL + 4) begin
            @(negedge clk);
            if (done || busy) cyc++;
        end
        chk("no_done_after_abort", 64'(cyc), 64'd0);

        run_op(64'd100, 64'd58, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
